data_ram: RTL and testbench



---
 rtl/data_ram.sv | 82 ++++++++
 tb/tb_data_ram.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Byte-writable single-port data memory for the core load/store bus.
// Read-first synchronous read, latency 1; qout clears asynchronously on reset.

module data_ram_array #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [XLEN/8-1:0]        wen_i,
    output logic [XLEN-1:0]          rdata_o
);

    localparam int unsigned NLANE = XLEN / 8;

    // Array name and [0:DEPTH-1] order are relied on by external preload.
    logic [XLEN-1:0] RAM [0:DEPTH-1];
    logic [XLEN-1:0] rdata_q;

    // Contents carry no reset so preloaded data survives it.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NLANE; i++) begin
            if (wen_i[i]) begin
                RAM[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Non-blocking read of the pre-write word gives read-first collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= RAM[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

module data_ram #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] addr,
    input  logic [XLEN-1:0]   qin,
    input  logic [3:0]        we,
    output logic [XLEN-1:0]   qout
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [IW-1:0] idx_c;
    logic [3:0]    wen_c;
    logic          unused_addr_c;

    // Upper address bits alias (wrap) and byte offset is ignored: no lane rotation.
    assign idx_c         = addr[2 +: IW];
    assign unused_addr_c = ^{addr[AWIDTH-1:2+IW], addr[1:0]};

    // Writes are suppressed for the whole time reset is held.
    assign wen_c = rst_n ? we : 4'b0000;

    data_ram_array #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) U_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx_i   (idx_c),
        .wdata_i (qin),
        .wen_i   (wen_c),
        .rdata_o (qout)
    );

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed scenarios plus randomized
// traffic checked against a byte-level array model.

module tb_data_ram;

    localparam int unsigned DEPTH = 4096;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] qin;
    logic [3:0]  we;
    logic [31:0] qout;

    int unsigned n_cmp;
    int unsigned n_err;

    logic [31:0] mem [0:DEPTH-1];

    data_ram #(
        .XLEN   (32),
        .AWIDTH (32),
        .DEPTH  (DEPTH)
    ) u_data_memory (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .qin   (qin),
        .we    (we),
        .qout  (qout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        return mem[widx(a)];
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        int unsigned k;
        logic [31:0] old;
        logic [31:0] nw;
        k   = widx(a);
        old = mem[k];
        nw  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] b;
            b  = w[i] ? ((d >> (8 * i)) & 32'hFF) : ((old >> (8 * i)) & 32'hFF);
            nw = nw | (b << (8 * i));
        end
        mem[k] = nw;
    endfunction

    // Apply one bus cycle, then sample 1 time unit after the edge.
    task automatic step(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        addr = a;
        we   = w;
        qin  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        addr  = 32'h0;
        we    = 4'h0;
        qin   = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [31:0] v;
            v = $urandom;
            u_data_memory.U_ram.RAM[i] <= v;
            mem[i] = v;
        end
        u_data_memory.U_ram.RAM[12'h200] <= 32'hDEADBEEF;
        mem[12'h200] = 32'hDEADBEEF;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (qout !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: qout=%h expected %h", qout, 32'h0);
        end
        // Write attempts during reset must be ignored.
        for (int i = 0; i < 2; i++) begin
            step(32'h800, 4'hF, 32'h0BAD0BAD);
            n_cmp++;
            if (qout !== 32'h0) begin
                n_err++;
                $display("FAIL reset_hold: qout=%h expected %h", qout, 32'h0);
            end
        end
        we    = 4'h0;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (qout !== 32'h0) begin
            n_err++;
            $display("FAIL reset_release: qout=%h expected %h", qout, 32'h0);
        end
    endtask

    task automatic test_preload;
        step(32'h800, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL preload_read: qout=%h expected %h", qout, 32'hDEADBEEF);
        end
    endtask

    task automatic test_byte_write;
        mwrite(32'h10, 4'hF, 32'h12345678);
        step(32'h10, 4'hF, 32'h12345678);
        step(32'h10, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== 32'h12345678) begin
            n_err++;
            $display("FAIL word_write: qout=%h expected %h", qout, 32'h12345678);
        end
        mwrite(32'h10, 4'b0010, 32'h0000AB00);
        step(32'h10, 4'b0010, 32'h0000AB00);
        step(32'h10, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== 32'h1234AB78 || qout !== mread(32'h10)) begin
            n_err++;
            $display("FAIL lane_write: qout=%h expected %h", qout, 32'h1234AB78);
        end
    endtask

    task automatic test_collision;
        mwrite(32'h20, 4'hF, 32'h11111111);
        step(32'h20, 4'hF, 32'h11111111);
        step(32'h20, 4'hF, 32'hCAFEF00D);
        mwrite(32'h20, 4'hF, 32'hCAFEF00D);
        n_cmp++;
        if (qout !== 32'h11111111) begin
            n_err++;
            $display("FAIL collision_old: qout=%h expected %h", qout, 32'h11111111);
        end
        step(32'h20, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL collision_new: qout=%h expected %h", qout, 32'hCAFEF00D);
        end
    endtask

    task automatic test_reset_midread;
        mwrite(32'h40, 4'hF, 32'h5A5A0001);
        step(32'h40, 4'hF, 32'h5A5A0001);
        step(32'h40, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== 32'h5A5A0001) begin
            n_err++;
            $display("FAIL midread_pre: qout=%h expected %h", qout, 32'h5A5A0001);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (qout !== 32'h0) begin
            n_err++;
            $display("FAIL midread_async: qout=%h expected %h", qout, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            step(32'h40, 4'hF, 32'hFFFFFFFF);
            n_cmp++;
            if (qout !== 32'h0) begin
                n_err++;
                $display("FAIL midread_hold: qout=%h expected %h", qout, 32'h0);
            end
        end
        we    = 4'h0;
        rst_n = 1'b1;
        step(32'h40, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== mread(32'h40)) begin
            n_err++;
            $display("FAIL midread_keep: qout=%h expected %h", qout, mread(32'h40));
        end
    endtask

    task automatic test_wrap;
        mwrite(DEPTH * 4, 4'hF, 32'hA5A5A5A5);
        step(DEPTH * 4, 4'hF, 32'hA5A5A5A5);
        step(32'h0, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL wrap: qout=%h expected %h", qout, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] ref10;
        step(32'h10, 4'h0, 32'h0);
        ref10 = mread(32'h10);
        n_cmp++;
        if (qout !== ref10) begin
            n_err++;
            $display("FAIL aligned_read: qout=%h expected %h", qout, ref10);
        end
        step(32'h13, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== ref10) begin
            n_err++;
            $display("FAIL misaligned_read: qout=%h expected %h", qout, ref10);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_v;
        // One lane per cycle into the same word, each read checking the previous state.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] w;
            logic [31:0] d;
            w = 4'(1 << i);
            d = $urandom;
            exp_v = mread(32'h84);
            mwrite(32'h84, w, d);
            step(32'h84, w, d);
            n_cmp++;
            if (qout !== exp_v) begin
                n_err++;
                $display("FAIL b2b_lane%0d: qout=%h expected %h", i, qout, exp_v);
            end
        end
        step(32'h84, 4'h0, 32'h0);
        n_cmp++;
        if (qout !== mread(32'h84)) begin
            n_err++;
            $display("FAIL b2b_final: qout=%h expected %h", qout, mread(32'h84));
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [3:0]  w;
            logic [31:0] d;
            logic [31:0] exp_v;
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2) | ($urandom & 32'h3);
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            d = $urandom;
            exp_v = mread(a);
            mwrite(a, w, d);
            step(a, w, d);
            n_cmp++;
            if (qout !== exp_v) begin
                n_err++;
                $display("FAIL random[%0d] addr=%h we=%b: qout=%h expected %h", n, a, w, qout, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_preload();
        test_byte_write();
        test_collision();
        test_reset_midread();
        test_wrap();
        test_misaligned();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
